bdm_target: RTL and testbench

Target-side responder for the single-wire BKGD debug interface: the MCU end of the link that the `bdm` host block drives. It decodes host-timed bit frames on BKGD into bytes, returns bytes in host-initiated read slots by stretching the low pulse, and answers SYNC requests with a timed low pulse. It is used as a bus-functional target model and as an MCU stand-in for hardware loopback of the programmer.

---
 rtl/bdm_target.sv | 217 +++++++++++++++++++++
 tb/tb_bdm_target.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bdm_target.sv
// bdm_target - MCU-side responder for the single-wire BKGD debug link.
//
// Decodes host-timed bit frames into bytes. A falling edge starts a frame, and
// the line is sampled SAMPLE_AT cycles later. When a TX byte is pending, the
// target answers read slots by stretching the host's low pulse for 0 bits.
// A low time of SYNC_MIN or more is a SYNC request. After the host releases
// the line, the target waits SYNC_DELAY cycles and then drives a SYNC_RESP
// cycle low pulse.
//
// Ports
//   clk, rst         clock; asynchronous active-low reset
//   bkgd_in          raw pin level, asynchronous to clk
//   bkgd_out         level driven while driving (always 0); 1 when released
//   bkgd_is_high_z   1 = line released
//   rx_data/rx_valid last received byte (MSB first), one-cycle update strobe
//   tx_data/tx_load  byte to return, load strobe (taken only when tx_ready)
//   tx_ready         no TX byte pending and no partial byte in flight
//   sync_detect      one-cycle pulse after the SYNC response ends
//   debug            current FSM state
module bdm_target #(
  parameter int SAMPLE_AT  = 10,
  parameter int ZERO_HOLD  = 13,
  parameter int SYNC_MIN   = 128,
  parameter int SYNC_DELAY = 16,
  parameter int SYNC_RESP  = 128,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bkgd_in,
  output logic       bkgd_out,
  output logic       bkgd_is_high_z,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic       sync_detect,
  output logic [3:0] debug
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    RX_LOW    = 4'd1,
    RX_HOLD   = 4'd2,
    TX_SLOT   = 4'd3,
    TX_END    = 4'd4,
    SYNC_WAIT = 4'd5,
    SYNC_DLY  = 4'd6,
    SYNC_DRV  = 4'd7
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_AT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(ZERO_HOLD - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST   = CNT_W'(SYNC_MIN - 1);
  localparam logic [CNT_W-1:0] DLY_LAST    = CNT_W'(SYNC_DELAY - 1);
  localparam logic [CNT_W-1:0] RESP_LAST   = CNT_W'(SYNC_RESP - 1);

  state_t           state, state_nx;
  logic             sync1, s, s_d;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [7:0]       sh, sh_nx;
  logic [2:0]       bitn, bitn_nx;
  logic             txp, txp_nx;
  logic [7:0]       rx_data_nx;
  logic             rx_valid_nx, sync_det_nx;
  logic             drive;
  logic             fall, rise;

  // The synchroniser resets to the idle-high level, so reset release
  // cannot create a phantom falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      s     <= 1'b1;
      s_d   <= 1'b1;
    end else begin
      sync1 <= bkgd_in;
      s     <= sync1;
      s_d   <= s;
    end
  end

  assign fall = s_d & ~s;
  assign rise = ~s_d & s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sh          <= '0;
      bitn        <= '0;
      txp         <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      sync_detect <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      sh          <= sh_nx;
      bitn        <= bitn_nx;
      txp         <= txp_nx;
      rx_data     <= rx_data_nx;
      rx_valid    <= rx_valid_nx;
      sync_detect <= sync_det_nx;
    end
  end

  assign tx_ready = ~txp & (bitn == 3'd0);

  always_comb begin
    state_nx    = state;
    cnt_nx      = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    sh_nx       = sh;
    bitn_nx     = bitn;
    txp_nx      = txp;
    rx_data_nx  = rx_data;
    rx_valid_nx = 1'b0;
    sync_det_nx = 1'b0;
    drive       = 1'b0;

    case (state)
      IDLE: begin
        if (fall) begin
          cnt_nx   = '0;
          state_nx = txp ? TX_SLOT : RX_LOW;
        end
      end

      // Sample once at a fixed offset. An early rise does not end the slot.
      RX_LOW: begin
        if (cnt == SAMPLE_LAST) begin
          sh_nx    = {sh[6:0], s};
          state_nx = RX_HOLD;
          if (bitn == 3'd7) begin
            rx_data_nx  = {sh[6:0], s};
            rx_valid_nx = 1'b1;
            bitn_nx     = 3'd0;
          end else begin
            bitn_nx = bitn + 3'd1;
          end
        end
      end

      // cnt keeps running from the fall, so a long low becomes a SYNC request.
      RX_HOLD: begin
        if (s)
          state_nx = IDLE;
        else if (cnt >= SYNC_LAST)
          state_nx = SYNC_WAIT;
      end

      // A 0 bit holds the line low from the cycle after the fall. A 1 bit
      // leaves the line to the host.
      TX_SLOT: begin
        drive = ~sh[7];
        if (cnt == HOLD_LAST) begin
          sh_nx    = {sh[6:0], 1'b0};
          state_nx = TX_END;
          if (bitn == 3'd7) begin
            bitn_nx = 3'd0;
            txp_nx  = 1'b0;
          end else begin
            bitn_nx = bitn + 3'd1;
          end
        end
      end

      // A long low in a read slot is not a SYNC. Wait here for the line to rise.
      TX_END: begin
        if (s)
          state_nx = IDLE;
      end

      SYNC_WAIT: begin
        bitn_nx = 3'd0;
        if (rise) begin
          cnt_nx   = '0;
          state_nx = SYNC_DLY;
        end
      end

      // Any fall seen in the next two states is the target's own drive,
      // so it is not decoded.
      SYNC_DLY: begin
        if (cnt == DLY_LAST) begin
          cnt_nx   = '0;
          state_nx = SYNC_DRV;
        end
      end

      SYNC_DRV: begin
        drive = 1'b1;
        if (cnt == RESP_LAST) begin
          state_nx    = IDLE;
          sync_det_nx = 1'b1;
        end
      end

      default: state_nx = IDLE;
    endcase

    // A load replaces the shift register only when nothing is in flight.
    if (tx_load && tx_ready) begin
      sh_nx  = tx_data;
      txp_nx = 1'b1;
    end
  end

  // The drive is decoded from the state, so an asynchronous reset releases
  // the line at once.
  assign bkgd_is_high_z = ~drive;
  assign bkgd_out       = ~drive;
  assign debug          = state;

endmodule

// File: tb/tb_bdm_target.sv
module tb_bdm_target;

  localparam int ZERO_HOLD  = 13;
  localparam int SYNC_DELAY = 16;
  localparam int SYNC_RESP  = 128;
  localparam int SLOT       = 40;   // host frame period in clk cycles

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       host_lvl = 1'b1;      // host open-drain: 0 pulls low
  logic       bkgd_in;
  logic       bkgd_out, bkgd_is_high_z;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       tx_ready, sync_detect;
  logic [3:0] debug;

  int checks = 0;
  int errors = 0;

  // Monitor counters. Only this block writes them.
  int n_rxv = 0, n_drv = 0, n_sync = 0;

  // The bus is a wired-AND of the host and the target.
  assign bkgd_in = host_lvl & (bkgd_is_high_z | bkgd_out);

  bdm_target dut (
    .clk(clk), .rst(rst), .bkgd_in(bkgd_in), .bkgd_out(bkgd_out),
    .bkgd_is_high_z(bkgd_is_high_z), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .sync_detect(sync_detect), .debug(debug)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) n_rxv++;
    if (!bkgd_is_high_z) n_drv++;
    if (sync_detect) n_sync++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One host frame. The host pulls low for 'low' cycles and samples the bus
  // 12 cycles after its fall. The frame is SLOT cycles long.
  task automatic frame(input int low, output logic smp, output int drv);
    int d0;
    d0  = n_drv;
    smp = 1'b1;
    @(posedge clk); #1 host_lvl = 1'b0;
    for (int c = 1; c <= SLOT; c++) begin
      @(posedge clk); #1;
      if (c == low) host_lvl = 1'b1;
      if (c == 12) smp = bkgd_in;
    end
    drv = n_drv - d0;
  endtask

  // A 1 needs a low time below 10 cycles. A 0 needs 11 cycles or more.
  task automatic send_bit(input logic b);
    logic smp;
    int   drv;
    frame(b ? int'($urandom_range(2, 8)) : int'($urandom_range(11, 30)), smp, drv);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic load(input logic [7:0] b);
    @(posedge clk); #1 tx_data = b; tx_load = 1'b1;
    @(posedge clk); #1 tx_load = 1'b0;
  endtask

  // Read a byte back. Each 0 bit must be stretched by exactly ZERO_HOLD
  // cycles of target drive, and no 1 bit may be driven.
  task automatic tx_byte(input logic [7:0] b, input int lo);
    logic [7:0] got;
    logic       smp;
    int         drv, rv0;
    rv0 = n_rxv;
    load(b);
    chk("tx_busy_after_load", tx_ready, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      frame((lo > 0) ? lo : int'($urandom_range(2, 8)), smp, drv);
      chk("tx_drive_len", drv, b[i] ? 0 : ZERO_HOLD);
      got[i] = smp;
    end
    chk("tx_host_byte", got, b);
    chk("tx_ready_after", tx_ready, 1'b1);
    chk("tx_no_rx_valid", n_rxv - rv0, 0);
  endtask

  // The host holds the line low for 200 cycles and then releases it. The gap
  // counts cycles from the release until the target starts to drive.
  task automatic sync_frame(output int gap, output int len, output logic det);
    gap = 0; len = 0; det = 1'b0;
    @(posedge clk); #1 host_lvl = 1'b0;
    repeat (200) @(posedge clk);
    #1 host_lvl = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!bkgd_is_high_z) break;
      gap++;
    end
    if (!bkgd_is_high_z) begin
      len = 1;
      for (int k = 0; k < 400; k++) begin
        @(negedge clk);
        if (bkgd_is_high_z) break;
        len++;
      end
      det = sync_detect;
    end
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] d55;
    int gap, len, rv0, s0, d0;
    logic det;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_hz", bkgd_is_high_z, 1'b1);
    chk("rst_out", bkgd_out, 1'b1);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("rst_sync", sync_detect, 1'b0);
    chk("rst_debug", debug, 4'd0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // RX 0x55 with low times alternating 13 and 4, starting with a 0
    rv0 = n_rxv; d0 = n_drv;
    d55 = 8'h55;
    for (int i = 7; i >= 0; i--) begin
      logic smp;
      int   drv;
      frame(d55[i] ? 4 : 13, smp, drv);
    end
    chk("rx55_data", rx_data, 8'h55);
    chk("rx55_pulses", n_rxv - rv0, 1);
    chk("rx55_tx_ready", tx_ready, 1'b1);
    chk("rx55_no_drive", n_drv - d0, 0);

    // Random RX bytes
    for (int n = 0; n < 4; n++) begin
      b = 8'($urandom);
      rv0 = n_rxv;
      send_byte(b);
      chk("rx_rand_data", rx_data, b);
      chk("rx_rand_pulses", n_rxv - rv0, 1);
    end

    // TX 0xA5 with 4-cycle host lows, then random TX bytes
    tx_byte(8'hA5, 4);
    for (int n = 0; n < 3; n++) tx_byte(8'($urandom), 0);

    // SYNC
    rv0 = n_rxv; s0 = n_sync;
    sync_frame(gap, len, det);
    // Two synchroniser flops and the edge-detect cycle come before the delay.
    chk("sync_gap", gap, SYNC_DELAY + 3);
    chk("sync_len", len, SYNC_RESP);
    chk("sync_detect_at_release", det, 1'b1);
    chk("sync_pulses", n_sync - s0, 1);
    chk("sync_no_rx_valid", n_rxv - rv0, 0);
    chk("sync_tx_ready", tx_ready, 1'b1);

    // SYNC mid-byte: the partial byte is discarded
    rv0 = n_rxv;
    b = 8'($urandom);
    for (int i = 7; i >= 5; i--) send_bit(b[i]);
    chk("mid_tx_ready_busy", tx_ready, 1'b0);
    sync_frame(gap, len, det);
    chk("mid_sync_len", len, SYNC_RESP);
    chk("mid_tx_ready_clear", tx_ready, 1'b1);
    send_byte(8'hFF);
    chk("mid_rx_data", rx_data, 8'hFF);
    chk("mid_rx_pulses", n_rxv - rv0, 1);

    // Ignored load during a partial receive
    rv0 = n_rxv; d0 = n_drv;
    b = 8'($urandom) | 8'h01;
    for (int i = 7; i >= 5; i--) send_bit(b[i]);
    chk("ign_tx_ready", tx_ready, 1'b0);
    load(8'h12);
    chk("ign_still_busy", tx_ready, 1'b0);
    for (int i = 4; i >= 0; i--) send_bit(b[i]);
    chk("ign_rx_data", rx_data, b);
    chk("ign_rx_pulses", n_rxv - rv0, 1);
    chk("ign_no_drive", n_drv - d0, 0);
    chk("ign_tx_ready_after", tx_ready, 1'b1);

    // Reset during a driven 0 bit releases the line immediately
    load(8'h3C);
    @(posedge clk); #1 host_lvl = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    chk("pre_rst_driving", bkgd_is_high_z, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_rst_hz", bkgd_is_high_z, 1'b1);
    chk("mid_rst_out", bkgd_out, 1'b1);
    host_lvl = 1'b1;
    @(negedge clk);
    chk("mid_rst_rx_data", rx_data, 8'h00);
    chk("mid_rst_rx_valid", rx_valid, 1'b0);
    chk("mid_rst_tx_ready", tx_ready, 1'b1);
    chk("mid_rst_sync", sync_detect, 1'b0);
    chk("mid_rst_debug", debug, 4'd0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Reception works again after the reset
    rv0 = n_rxv;
    b = 8'($urandom);
    send_byte(b);
    chk("post_rst_rx_data", rx_data, b);
    chk("post_rst_pulses", n_rxv - rv0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
